averager_sequencer: RTL and testbench

AVERAGER_SEQUENCER -- requirements
Module: averager_sequencer

---
 rtl/averager_pkg.sv | 20 ++
 rtl/averager_watchdog.sv | 32 +++
 rtl/averager_sequencer.sv | 124 ++++++++++++
 tb/tb_averager_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/averager_pkg.sv
// Shared types and defaults for the averager acquisition sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (sequencer FSM states), DEFAULT_WIDTH, DEFAULT_TIMEOUT_CYCLES.
package averager_pkg;

  localparam int DEFAULT_WIDTH          = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT_CLR,
    RUN,
    DONE,
    FAULT
  } state_t;

endpackage

// File: rtl/averager_watchdog.sv
// Stall watchdog: counts enabled cycles, flags expiry at TIMEOUT_CYCLES-1.
// Latency: expired follows the registered count combinationally (0 cycles).
// Backpressure: none; clear wins over enable, count saturates at the limit.
// Ports: clk, rst (sync, active-high), clear, enable -> expired.
module averager_watchdog
  import averager_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable && (r_count == LIMIT);

endmodule

// File: rtl/averager_sequencer.sv
// Acquisition sequencer for an averager: loads config, restarts, waits for target count.
// Latency: start -> restart is 2 cycles; all outputs registered.
// Backpressure: none; start ignored while busy, abort returns to IDLE next cycle.
// Ports: clk, rst | start, abort, cfg_* -> period, threshold, avg_off, restart |
//        avg_ready, avg_n (from averager) | busy, done, error, acq_count (status).
module averager_sequencer
  import averager_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_threshold,
  input  logic                cfg_avg_on,
  input  logic [32-WIDTH-1:0] cfg_n_target,
  input  logic                avg_ready,
  input  logic [32-WIDTH-1:0] avg_n,
  output logic                restart,
  output logic                avg_off,
  output logic [WIDTH-1:0]    period,
  output logic [WIDTH-1:0]    threshold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         acq_count
);

  localparam int NW = 32 - WIDTH;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NW-1:0]   r_target;
  logic [NW-1:0]   r_avg_n_prev;
  logic            w_in_watch;
  logic            w_avg_n_chg;
  logic            w_expired;

  assign w_in_watch  = (r_state == WAIT_CLR) || (r_state == RUN);
  assign w_avg_n_chg = (avg_n != r_avg_n_prev);

  // Progress on the averager (any change of avg_n) restarts the stall timer;
  // the timer is held at zero outside the two waiting states, so entering
  // WAIT_CLR always starts from a clean count.
  averager_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!w_in_watch || w_avg_n_chg),
    .enable (w_in_watch),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_avg_n_prev <= '0;
    end else begin
      r_avg_n_prev <= avg_n;
    end
  end

  // Next-state decode. Forward progress wins over the watchdog when both
  // land in the same cycle; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE, FAULT: if (start) w_state_nxt = LOAD;
      LOAD:              w_state_nxt = (cfg_threshold >= cfg_period) ? FAULT : ARM;
      ARM:               w_state_nxt = WAIT_CLR;
      WAIT_CLR: begin
        if (avg_n == '0)    w_state_nxt = RUN;
        else if (w_expired) w_state_nxt = FAULT;
      end
      RUN: begin
        if (avg_ready && (avg_n >= r_target)) w_state_nxt = DONE;
        else if (w_expired)                   w_state_nxt = FAULT;
      end
      default:           w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // State and every output register together; status flags are decoded
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_target  <= NW'(1);
      restart   <= 1'b0;
      avg_off   <= 1'b0;
      period    <= '0;
      threshold <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      acq_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      restart <= (w_state_nxt == ARM);
      busy    <= (w_state_nxt == LOAD) || (w_state_nxt == ARM) ||
                 (w_state_nxt == WAIT_CLR) || (w_state_nxt == RUN);
      done    <= (w_state_nxt == DONE);
      error   <= (w_state_nxt == FAULT);

      if ((r_state == LOAD) && (w_state_nxt == ARM)) begin
        period    <= cfg_period;
        threshold <= cfg_threshold;
        avg_off   <= ~cfg_avg_on;
        // A zero or bypassed target would complete on the stale count, so
        // the minimum meaningful target is one sample.
        r_target  <= (!cfg_avg_on || (cfg_n_target == '0)) ? NW'(1) : cfg_n_target;
      end

      if ((r_state == RUN) && (w_state_nxt == DONE)) begin
        acq_count <= acq_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_averager_sequencer.sv
// Self-checking bench for averager_sequencer (WIDTH=8, TIMEOUT_CYCLES=16).
// Expected completions/faults are queued at launch and matched by a monitor.
// Inputs are driven 1 time unit after the rising edge; outputs sampled there too.
module tb_averager_sequencer;

  localparam int W  = 8;
  localparam int NW = 32 - W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  cfg_period;
  logic [W-1:0]  cfg_threshold;
  logic          cfg_avg_on;
  logic [NW-1:0] cfg_n_target;
  logic          avg_ready;
  logic [NW-1:0] avg_n;
  logic          restart;
  logic          avg_off;
  logic [W-1:0]  period;
  logic [W-1:0]  threshold;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   acq_count;

  averager_sequencer #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_period   (cfg_period),
    .cfg_threshold(cfg_threshold),
    .cfg_avg_on   (cfg_avg_on),
    .cfg_n_target (cfg_n_target),
    .avg_ready    (avg_ready),
    .avg_n        (avg_n),
    .restart      (restart),
    .avg_off      (avg_off),
    .period       (period),
    .threshold    (threshold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .acq_count    (acq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int acq;
    int period;
    int thr;
    bit off;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Model of the applied configuration and completion count.
  int m_period = 0;
  int m_thr    = 0;
  bit m_off    = 1'b0;
  int m_target = 1;
  int m_acq    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_restart"},   32'(restart),   32'(0));
    chk({tag, "_avg_off"},   32'(avg_off),   32'(0));
    chk({tag, "_period"},    32'(period),    32'(0));
    chk({tag, "_threshold"}, 32'(threshold), 32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
    chk({tag, "_done"},      32'(done),      32'(0));
    chk({tag, "_error"},     32'(error),     32'(0));
    chk({tag, "_acq"},       32'(acq_count), 32'(0));
  endtask

  // Drive one start pulse with the given config, queue the expected outcome
  // and check the start->LOAD->ARM timing including the restart pulse.
  task automatic launch(input int p, input int thr, input bit on, input int ntg,
                        input bit push, input bit exp_done);
    exp_t e;
    bit   ok;
    ok = (thr < p);
    if (ok) begin
      m_period = p;
      m_thr    = thr;
      m_off    = !on;
      m_target = (!on || ntg == 0) ? 1 : ntg;
    end
    if (push) begin
      e.is_done = ok && exp_done;
      e.acq     = e.is_done ? ((m_acq + 1) & 16'hffff) : m_acq;
      if (e.is_done) m_acq = e.acq;
      e.period  = m_period;
      e.thr     = m_thr;
      e.off     = m_off;
      sb_q.push_back(e);
    end
    cfg_period    = W'(p);
    cfg_threshold = W'(thr);
    cfg_avg_on    = on;
    cfg_n_target  = NW'(ntg);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy",    32'(busy),    32'(1));
    chk("load_restart", 32'(restart), 32'(0));
    tick();
    chk("arm_restart",  32'(restart), 32'(ok));
    chk("arm_error",    32'(error),   32'(!ok));
    chk("arm_period",   32'(period),  32'(m_period));
    chk("arm_thr",      32'(threshold), 32'(m_thr));
    chk("arm_avg_off",  32'(avg_off), 32'(m_off));
    tick();
    chk("post_restart", 32'(restart), 32'(0));
  endtask

  // One cycle at avg_n==0 lets WAIT_CLR move to RUN, then count up with
  // avg_ready until the sequencer reports completion (bounded by maxv).
  task automatic feed(input int maxv);
    bit hit = 1'b0;
    avg_n     = '0;
    avg_ready = 1'b0;
    tick();
    chk("run_busy", 32'(busy), 32'(1));
    for (int v = 1; v <= maxv && !hit; v++) begin
      avg_n     = NW'(v);
      avg_ready = 1'b1;
      tick();
      chk("done_at_n", 32'(done), 32'(v >= m_target));
      if (done === 1'b1) hit = 1'b1;
    end
    if (!hit) chk("feed_bound", 32'(done), 32'(1));
    avg_n     = '0;
    avg_ready = 1'b0;
  endtask

  // Scoreboard monitor: every rising done/error must match the queued outcome.
  initial begin
    exp_t e;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if ((done === 1'b1 && prev_done !== 1'b1) || (error === 1'b1 && prev_err !== 1'b1)) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 32'(done | error), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("sb_kind",   32'(done),      32'(e.is_done));
          chk("sb_err",    32'(error),     32'(!e.is_done));
          chk("sb_acq",    32'(acq_count), 32'(e.acq));
          chk("sb_period", 32'(period),    32'(e.period));
          chk("sb_thr",    32'(threshold), 32'(e.thr));
          chk("sb_off",    32'(avg_off),   32'(e.off));
        end
      end
      prev_done = done;
      prev_err  = error;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    cfg_period    = '0;
    cfg_threshold = '0;
    cfg_avg_on    = 1'b0;
    cfg_n_target  = '0;
    avg_ready     = 1'b0;
    avg_n         = '0;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'(0));

    // Normal averaged run, target 4.
    launch(255, 250, 1'b1, 4, 1'b1, 1'b1);
    feed(8);

    // Threshold equal to period is rejected; applied config is retained.
    launch(255, 255, 1'b1, 4, 1'b1, 1'b0);
    chk("fault_restart", 32'(restart), 32'(0));

    // Bypass mode from FAULT: target collapses to one sample.
    launch(200, 10, 1'b0, 100, 1'b1, 1'b1);
    feed(4);

    // Largest legal threshold with a zero target (treated as one).
    launch(100, 99, 1'b1, 0, 1'b1, 1'b1);
    feed(4);

    // Stalled averager: avg_n frozen at 2 in RUN trips the watchdog.
    launch(50, 20, 1'b1, 8, 1'b1, 1'b0);
    avg_n     = '0;
    avg_ready = 1'b0;
    tick();
    avg_n     = NW'(2);
    avg_ready = 1'b1;
    repeat (16) tick();
    chk("wd_early", 32'(error), 32'(0));
    tick();
    chk("wd_fire",  32'(error), 32'(1));
    chk("wd_busy",  32'(busy),  32'(0));
    avg_n     = '0;
    avg_ready = 1'b0;

    // Restart from FAULT completes normally.
    launch(60, 30, 1'b1, 3, 1'b1, 1'b1);
    feed(6);

    // Abort together with start while in RUN.
    launch(80, 40, 1'b1, 5, 1'b0, 1'b0);
    avg_n = '0;
    tick();
    avg_n     = NW'(1);
    avg_ready = 1'b1;
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start     = 1'b0;
    abort     = 1'b0;
    avg_n     = '0;
    avg_ready = 1'b0;
    chk("abort_busy",  32'(busy),      32'(0));
    chk("abort_done",  32'(done),      32'(0));
    chk("abort_err",   32'(error),     32'(0));
    chk("abort_acq",   32'(acq_count), 32'(m_acq));
    tick();
    chk("abort_stays_idle", 32'(busy), 32'(0));

    // Reset mid-RUN beats simultaneous start and abort.
    launch(90, 45, 1'b1, 5, 1'b0, 1'b0);
    avg_n = '0;
    tick();
    avg_n     = NW'(1);
    avg_ready = 1'b1;
    tick();
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    chk_reset("midrun_rst");
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    avg_n     = '0;
    avg_ready = 1'b0;
    m_period  = 0;
    m_thr     = 0;
    m_off     = 1'b0;
    m_target  = 1;
    m_acq     = 0;
    tick();

    // Counter restarts from zero after reset.
    launch(30, 3, 1'b1, 2, 1'b1, 1'b1);
    feed(4);
    tick();
    tick();

    chk("sb_drain", 32'(sb_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
